// File: rtl/sobel_pkg.sv
// Shared types and constants for the RGB888-to-luma front end of the Sobel pipeline.
// Gray-source selection, coefficient sets and RGB field positions.
package sobel_pkg;

    typedef enum logic [1:0] {
        GRAY_LUMA = 2'd0,
        GRAY_R    = 2'd1,
        GRAY_G    = 2'd2,
        GRAY_B    = 2'd3
    } gray_sel_e;

    localparam logic [8:0] LUMA_RC = 9'd77;
    localparam logic [8:0] LUMA_GC = 9'd150;
    localparam logic [8:0] LUMA_BC = 9'd29;
    localparam logic [8:0] UNITY_C = 9'd256;

    localparam int unsigned ROUND_C = 128;
    localparam int unsigned SHIFT   = 8;

    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_LSB = 0;

    typedef struct packed {
        logic [8:0] rc;
        logic [8:0] gc;
        logic [8:0] bc;
    } coef_t;

    function automatic coef_t sel_coef(input gray_sel_e sel);
        coef_t c;
        case (sel)
            GRAY_R:  c = '{rc: UNITY_C, gc: '0, bc: '0};
            GRAY_G:  c = '{rc: '0, gc: UNITY_C, bc: '0};
            GRAY_B:  c = '{rc: '0, gc: '0, bc: UNITY_C};
            default: c = '{rc: LUMA_RC, gc: LUMA_GC, bc: LUMA_BC};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sobel_rgb2y_if.sv
// Pixel stream handshakes around the luma converter: RGB in, Y out.
// master = upstream/downstream environment, slave = converter.
interface sobel_rgb2y_if;
    logic [23:0] rgb_data;
    logic        rgb_valid;
    logic        rgb_ready;
    logic [7:0]  y_data;
    logic        y_valid;
    logic        y_ready;

    modport master (
        output rgb_data, rgb_valid, y_ready,
        input  rgb_ready, y_data, y_valid
    );

    modport slave (
        input  rgb_data, rgb_valid, y_ready,
        output rgb_ready, y_data, y_valid
    );
endinterface

// File: rtl/sobel_pix_counter.sv
// Raster position counter: x wraps at IMG_W-1 and bumps y, y wraps at IMG_H-1.
// Flags the first and last pixel of the frame for the current position.
module sobel_pix_counter #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             inc,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             at_first,
    output logic             at_last
);
    localparam logic [CNT_W-1:0] X_MAX = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(IMG_H - 1);

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (inc) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign at_first = (x_q == '0) && (y_q == '0);
    assign at_last  = (x_q == X_MAX) && (y_q == Y_MAX);
endmodule

// File: rtl/sobel_rgb2y.sv
// Two-stage RGB888-to-gray converter feeding the Sobel line buffers.
// S1 registers the three channel products, S2 rounds/saturates; frame tracking on both sides.
module sobel_rgb2y
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned CNT_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_p,
    input  logic [1:0]           cfg_gray_sel,
    sobel_rgb2y_if.slave         bus,
    output logic                 frame_done,
    output logic                 busy
);
    logic        s1_free, s2_free, in_xfer, out_xfer;
    logic        in_first, in_last, out_first, out_last;
    gray_sel_e   sel_q, sel_d, eff_sel;
    coef_t       coef;
    logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [15:0] r_prod_q, r_prod_d, g_prod_q, g_prod_d, b_prod_q, b_prod_d;
    logic [7:0]  y_q, y_d;
    logic        frame_done_q, frame_done_d, busy_q, busy_d;
    logic [16:0] sum;
    logic [17:0] rounded;
    logic [9:0]  scaled;
    logic [7:0]  y_sat;

    sobel_pix_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)) u_in_cnt (
        .clk(clk), .rst_p(rst_p), .inc(in_xfer),
        .x(), .y(), .at_first(in_first), .at_last(in_last)
    );

    sobel_pix_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)) u_out_cnt (
        .clk(clk), .rst_p(rst_p), .inc(out_xfer),
        .x(), .y(), .at_first(out_first), .at_last(out_last)
    );

    always_comb begin
        s2_free  = !s2_valid_q || bus.y_ready;
        s1_free  = !s1_valid_q || s2_free;
        in_xfer  = bus.rgb_valid && s1_free;
        out_xfer = s2_valid_q && bus.y_ready;

        // The frame's first pixel must already use the selection being latched with it.
        eff_sel = in_first ? gray_sel_e'(cfg_gray_sel) : sel_q;
        coef    = sel_coef(eff_sel);

        sel_d      = sel_q;
        s1_valid_d = s1_valid_q;
        r_prod_d   = r_prod_q;
        g_prod_d   = g_prod_q;
        b_prod_d   = b_prod_q;
        if (in_xfer && in_first) sel_d = gray_sel_e'(cfg_gray_sel);
        if (s1_free) s1_valid_d = bus.rgb_valid;
        if (in_xfer) begin
            r_prod_d = 16'(coef.rc) * 16'(bus.rgb_data[R_LSB +: 8]);
            g_prod_d = 16'(coef.gc) * 16'(bus.rgb_data[G_LSB +: 8]);
            b_prod_d = 16'(coef.bc) * 16'(bus.rgb_data[B_LSB +: 8]);
        end

        sum     = 17'(r_prod_q) + 17'(g_prod_q) + 17'(b_prod_q);
        rounded = 18'(sum) + 18'(ROUND_C);
        scaled  = 10'(rounded >> SHIFT);
        y_sat   = (scaled > 10'd255) ? 8'hFF : scaled[7:0];

        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) y_d = y_sat;
        end

        frame_done_d = out_xfer && out_last;
        // Input counter off (0,0) at frame end means the next frame is already entering.
        busy_d = busy_q;
        if (in_xfer && in_first) busy_d = 1'b1;
        else if (out_xfer && out_last) busy_d = !in_first;
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            sel_q        <= GRAY_LUMA;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            r_prod_q     <= '0;
            g_prod_q     <= '0;
            b_prod_q     <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            r_prod_q     <= r_prod_d;
            g_prod_q     <= g_prod_d;
            b_prod_q     <= b_prod_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.rgb_ready = s1_free;
    assign bus.y_data    = y_q;
    assign bus.y_valid   = s2_valid_q;
    assign frame_done    = frame_done_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_sobel_rgb2y.sv
// Directed bench for sobel_rgb2y on a 4x2 frame with hand-computed gray values.
module tb_sobel_rgb2y;
    localparam int unsigned W = 4;
    localparam int unsigned H = 2;

    logic       clk = 1'b0;
    logic       rst_p;
    logic [1:0] cfg_gray_sel;
    logic       frame_done;
    logic       busy;

    sobel_rgb2y_if bus();

    sobel_rgb2y #(.IMG_W(W), .IMG_H(H), .CNT_W(4)) dut (
        .clk(clk),
        .rst_p(rst_p),
        .cfg_gray_sel(cfg_gray_sel),
        .bus(bus),
        .frame_done(frame_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_q[$];
    int out_cyc[$];
    int in_cyc[$];
    int fd_cyc[$];
    int fd_busy[$];
    int fd_busy_prev[$];
    logic busy_prev = 1'b0;
    logic stop = 1'b0;

    logic [23:0] tab [8] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                             {8'd100, 8'd150, 8'd200}, 24'h000000,
                             {8'd10, 8'd200, 8'd30}, 24'h010101};
    int luma_y [8] = '{255, 77, 149, 29, 141, 0, 124, 1};
    int g_y    [8] = '{255, 0, 255, 0, 150, 0, 200, 1};

    // Transfers are recorded at the negedge preceding the edge that completes them.
    always @(negedge clk) begin
        cyc++;
        if (bus.rgb_valid && bus.rgb_ready) in_cyc.push_back(cyc);
        if (bus.y_valid && bus.y_ready) begin
            out_q.push_back(int'(bus.y_data));
            out_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_cyc.push_back(cyc);
            fd_busy.push_back(int'(busy));
            fd_busy_prev.push_back(int'(busy_prev));
        end
        busy_prev = busy;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        out_q.delete();
        out_cyc.delete();
        in_cyc.delete();
        fd_cyc.delete();
        fd_busy.delete();
        fd_busy_prev.delete();
    endtask

    task automatic do_reset();
        bus.rgb_valid = 1'b0;
        rst_p = 1'b1;
        tick();
        rst_p = 1'b0;
        clear_mon();
    endtask

    task automatic idle();
        bus.rgb_valid = 1'b0;
        tick();
    endtask

    task automatic send(input logic [23:0] p);
        int n = 0;
        bus.rgb_data  = p;
        bus.rgb_valid = 1'b1;
        @(negedge clk);
        while (!bus.rgb_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.rgb_ready) chk("send_timeout", 0, 1);
        tick();
    endtask

    task automatic wait_outs(input string tag, input int n);
        int k = 0;
        while (out_q.size() < n && k < 300) begin
            tick();
            k++;
        end
        repeat (4) tick();
        chk(tag, out_q.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_p         = 1'b1;
        cfg_gray_sel  = 2'd0;
        bus.rgb_valid = 1'b0;
        bus.rgb_data  = '0;
        bus.y_ready   = 1'b1;
        repeat (2) tick();
        chk("rst_y_valid", int'(bus.y_valid), 0);
        chk("rst_y_data", int'(bus.y_data), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rgb_ready", int'(bus.rgb_ready), 1);
        rst_p = 1'b0;
        clear_mon();

        // Luma, back to back, 2-cycle latency.
        for (int i = 0; i < 5; i++) send(tab[i]);
        idle();
        wait_outs("t1_count", 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t1_y%0d", i), qat(out_q, i), luma_y[i]);
            chk($sformatf("t1_lat%0d", i), qat(out_cyc, i) - qat(in_cyc, i), 2);
        end
        chk("t1_contig", qat(out_cyc, 4) - qat(out_cyc, 0), 4);

        // Backpressure: two accepts then stall with the first result held.
        do_reset();
        bus.y_ready = 1'b0;
        send(tab[1]);
        send(tab[2]);
        bus.rgb_data  = tab[3];
        bus.rgb_valid = 1'b1;
        repeat (3) tick();
        chk("t2_ready_low", int'(bus.rgb_ready), 0);
        chk("t2_y_valid", int'(bus.y_valid), 1);
        chk("t2_y_hold", int'(bus.y_data), 77);
        chk("t2_accepts", in_cyc.size(), 2);
        bus.y_ready = 1'b1;
        send(tab[3]);
        idle();
        wait_outs("t2_count", 3);
        chk("t2_y0", qat(out_q, 0), 77);
        chk("t2_y1", qat(out_q, 1), 149);
        chk("t2_y2", qat(out_q, 2), 29);

        // Full frame with random gaps and random downstream ready.
        do_reset();
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(0, 2)) idle();
                    send(tab[i]);
                end
                idle();
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    bus.y_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.y_ready = 1'b1;
        wait_outs("t3_count", 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_y%0d", i), qat(out_q, i), luma_y[i]);
        chk("t3_fd_count", fd_cyc.size(), 1);
        chk("t3_fd_delay", qat(fd_cyc, 0) - qat(out_cyc, 7), 1);
        chk("t3_busy_at_fd", qat(fd_busy, 0), 0);
        chk("t3_busy_before_fd", qat(fd_busy_prev, 0), 1);

        // Mid-frame sel change ignored; second frame picks up G.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send({8'd10, 8'd200, 8'd30});
            if (i == 2) cfg_gray_sel = 2'd2;
        end
        for (int i = 0; i < 8; i++) send(tab[i]);
        idle();
        wait_outs("t4_count", 16);
        for (int i = 0; i < 8; i++) chk($sformatf("t4_f1_y%0d", i), qat(out_q, i), 124);
        for (int i = 0; i < 8; i++) chk($sformatf("t4_f2_y%0d", i), qat(out_q, 8 + i), g_y[i]);

        // Reset with two pixels in flight at input position (2,1).
        do_reset();
        cfg_gray_sel = 2'd0;
        for (int i = 0; i < 4; i++) send(tab[i]);
        idle();
        repeat (3) tick();
        bus.y_ready = 1'b0;
        send(tab[4]);
        send(tab[5]);
        bus.rgb_valid = 1'b0;
        chk("t5_inflight", int'(bus.y_valid), 1);
        rst_p = 1'b1;
        tick();
        rst_p = 1'b0;
        chk("t5_y_valid", int'(bus.y_valid), 0);
        chk("t5_busy", int'(busy), 0);
        clear_mon();
        bus.y_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(tab[i]);
        idle();
        wait_outs("t5_count", 8);
        chk("t5_fd_count", fd_cyc.size(), 1);
        chk("t5_fd_delay", qat(fd_cyc, 0) - qat(out_cyc, 7), 1);
        chk("t5_y0", qat(out_q, 0), 255);
        chk("t5_y7", qat(out_q, 7), 1);

        // Back-to-back frames, sel switch at the boundary.
        do_reset();
        cfg_gray_sel = 2'd0;
        for (int i = 0; i < 7; i++) send(tab[7]);
        send(tab[1]);
        cfg_gray_sel = 2'd1;
        send(tab[1]);
        for (int i = 0; i < 7; i++) send(tab[7]);
        idle();
        wait_outs("t6_count", 16);
        chk("t6_tail", qat(out_q, 7), 77);
        chk("t6_head", qat(out_q, 8), 255);
        chk("t6_next", qat(out_q, 9), 1);
        chk("t6_fd_count", fd_cyc.size(), 2);
        chk("t6_fd1_delay", qat(fd_cyc, 0) - qat(out_cyc, 7), 1);
        chk("t6_busy_at_fd1", qat(fd_busy, 0), 1);
        chk("t6_busy_at_fd2", qat(fd_busy, 1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sobel_rgb2y.md
Name: sobel_rgb2y

Overview:
Pipelined RGB888-to-luma converter that sits directly upstream of the Sobel control stage. It produces the 8-bit Y stream that feeds the line buffers through a valid/ready handshake.
- Gray source is selectable per frame: BT.601 luma or a single colour channel.
- Tracks pixel position on both sides and pulses frame_done when the last pixel of a frame leaves the block.

Parameters:
IMG_W, 640, active pixels per line (≥2)
IMG_H, 480, active lines per frame (≥2)
CNT_W, 12, width of x/y position counters (must hold IMG_W-1 and IMG_H-1)

Ports:
clk  in  1  single clock; all logic rising-edge
rst_p  in  1  synchronous active-high reset
cfg_gray_sel  in  2  gray source: 0 luma, 1 R, 2 G, 3 B
rgb_data  in  24  R[23:16], G[15:8], B[7:0]
rgb_valid  in  1  upstream pixel valid
rgb_ready  out  1  block accepts pixel this cycle
y_data  out  8  gray pixel to Sobel control stage
y_valid  out  1  y_data valid
y_ready  in  1  Sobel control stage accepts
frame_done  out  1  one-cycle pulse: last pixel of frame transferred on output
busy  out  1  frame in progress (first input accepted, last output not yet transferred)

Behaviour:
- Reset (rst_p=1 at a clock edge), regardless of traffic:
  - all stage valids=0; y_valid=0, y_data=0, frame_done=0, busy=0.
  - both counters go to (0,0); latched sel=0.
  - in-flight pixels are dropped, and the next accepted pixel is frame pixel (0,0).
- Input transfer = rgb_valid & rgb_ready. Output transfer = y_valid & y_ready.
- Two register stages, S1 and S2, each with its own valid. Latency is 2 cycles from input transfer to y_valid when not stalled; throughput is 1 pixel/clk.
- Stage advance:
  - s2_free = !s2_valid | y_ready.
  - s1_free = !s1_valid | s2_free.
  - rgb_ready = s1_free (combinational through y_ready; accepted).
  - A stage holds data and valid while blocked.
  - y_data/y_valid are S2 registers and are stable while y_valid & !y_ready.
- S1: registers three 16-bit products Rc*R, Gc*G, Bc*B. Coefficients come from the latched sel:
  - sel 0: 77, 150, 29.
  - sel 1: 256, 0, 0.
  - sel 2: 0, 256, 0.
  - sel 3: 0, 0, 256.
- S2: sum is 17 bits; y = (sum + 128) >> 8, then saturated to 255. With the above coefficients the value never exceeds 255; the saturation is kept as a guard.
- Sel latching: cfg_gray_sel is sampled only on the input transfer where the input counter is (0,0). Between frame starts, changes to cfg_gray_sel have no effect.
- Input counter (in_x, in_y) advances on every input transfer:
  - x wraps at IMG_W-1 → 0 and increments y.
  - y wraps at IMG_H-1 → 0.
- Output counter (out_x, out_y) advances the same way on every output transfer.
- frame_done = registered pulse, high for exactly one cycle, in the cycle after the output transfer at (IMG_W-1, IMG_H-1).
- busy:
  - set on the input transfer at (0,0).
  - cleared in the same cycle frame_done rises, unless an input transfer at (0,0) occurs on that same edge; in that case busy stays 1.
- Back-to-back frames are allowed with no bubble. The next frame's sel is latched while the previous frame's tail is still in S1/S2, and that tail keeps its own products already computed.
- Counters and the pipeline hold while rgb_valid=0 or y_ready=0. There are no timeouts.

Decomposition:
- sobel_pkg holds:
  - gray-sel enum (GRAY_LUMA, GRAY_R, GRAY_G, GRAY_B).
  - luma coefficients (77/150/29), round constant 128, shift 8.
  - RGB bit-field offsets.
- One sub-module, sobel_pix_counter (params IMG_W, IMG_H, CNT_W):
  - inputs: clk, rst_p, inc.
  - outputs: x, y, at_first, at_last.
  - instantiated twice, for the input and output sides.

Test Plan:
- sel=0, y_ready=1, push (255,255,255), (255,0,0), (0,255,0), (0,0,255), (100,150,200) back to back → y = 255, 77, 149, 29, 141. Each appears 2 cycles after its input; y_valid is continuous.
- y_ready=0 with 3 pixels offered → y_valid=1 holding the first y; rgb_ready drops after 2 accepts. Raise y_ready → all 3 are delivered in order with no loss or duplicate.
- IMG_W=4, IMG_H=2, 8 pixels with random valid gaps and random y_ready → frame_done pulses exactly once, 1 cycle after the 8th output transfer; busy falls in the same cycle.
- Change cfg_gray_sel from 0 to 2 mid-frame, then send a second frame → first frame is luma throughout. Second frame outputs equal the G channel, e.g. (10,200,30) → 200.
- Assert rst_p for 1 cycle with 2 pixels in flight at (2,1) → the next cycle has y_valid=0 and busy=0. The next input is treated as (0,0); the following frame_done comes after IMG_W*IMG_H new outputs.
- Two frames back to back with no idle, where frame 1 ends with (255,0,0) under sel=0 and frame 2 starts with the same pixel under sel=1 → outputs 77 then 255. busy stays 1 across the boundary; frame_done pulses once at the end of frame 1.
